// File: rtl/rv_muldiv_unit_if.sv
// rv_muldiv_unit_if: request/response bundle between the execute stage
// and the iterative multiply/divide unit.
interface rv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush,
        output in_valid,
        output op,
        output src_a,
        output src_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  busy
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  op,
        input  src_a,
        input  src_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output busy
    );
endinterface

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide beside the execute ALU.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module rv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    rv_muldiv_unit_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [XLEN-1:0]   ONE_X   = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_2X  = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   MIN_X   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(XLEN);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ld_q, ld_d;
    logic [2:0]        op_q, op_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              in_sa, in_sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   spec_res;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     div_sh, div_dif;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] step_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   fin_res;

    // Which operands of the incoming funct3 are treated as signed.
    always_comb begin
        in_sa = bus.op[2] ? ~bus.op[0] : (bus.op[1] ^ bus.op[0]);
        in_sb = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] == 2'b01);
        in_sa = in_sa & bus.src_a[XLEN-1];
        in_sb = in_sb & bus.src_b[XLEN-1];
    end

    always_comb begin
        a_mag    = sa_q ? (~a_q + ONE_X) : a_q;
        b_mag    = sb_q ? (~b_q + ONE_X) : b_q;
        div_zero = op_q[2] && (b_q == '0);
        div_ovf  = op_q[2] && !op_q[0] && (a_q == MIN_X) && (b_q == '1);
        if (div_zero)
            spec_res = op_q[1] ? a_q : '1;
        else
            spec_res = op_q[1] ? '0 : a_q;
    end

    // One iteration: multiply shifts the product right, divide shifts left.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
        div_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_dif = div_sh - {1'b0, b_q};
        if (div_dif[XLEN])
            div_nxt = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            div_nxt = {div_dif[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        step_nxt = op_q[2] ? div_nxt : mul_nxt;
    end

    always_comb begin
        prod = neg_q ? (~step_nxt + ONE_2X) : step_nxt;
        quo  = step_nxt[XLEN-1:0];
        rem  = step_nxt[2*XLEN-1:XLEN];
        quo  = neg_q ? (~quo + ONE_X) : quo;
        rem  = sa_q ? (~rem + ONE_X) : rem;
        unique case (1'b1)
            !op_q[2] && (op_q[1:0] == 2'b00): fin_res = prod[XLEN-1:0];
            !op_q[2] && (op_q[1:0] != 2'b00): fin_res = prod[2*XLEN-1:XLEN];
            op_q[2] && !op_q[1]:              fin_res = quo;
            default:                          fin_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_d     = ld_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        neg_d    = neg_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (bus.flush) begin
            state_d = IDLE;
            ld_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_d = CALC;
                        ld_d    = 1'b1;
                        cnt_d   = CNT_MAX;
                        op_d    = bus.op;
                        a_d     = bus.src_a;
                        b_d     = bus.src_b;
                        sa_d    = in_sa;
                        sb_d    = in_sb;
                        neg_d   = in_sa ^ in_sb;
                    end
                end
                CALC: begin
                    // First CALC cycle forms magnitudes or settles the
                    // RISC-V defined divide corner cases.
                    if (ld_q) begin
                        ld_d = 1'b0;
                        if (div_zero || div_ovf) begin
                            result_d = spec_res;
                            state_d  = DONE;
                        end else begin
                            acc_d = {{XLEN{1'b0}}, a_mag};
                            b_d   = b_mag;
                        end
                    end else begin
                        acc_d = step_nxt;
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            result_d = fin_res;
                            state_d  = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ld_q     <= 1'b0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_q     <= ld_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            neg_q    <= neg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: directed and randomized checks of rv_muldiv_unit
// against an arithmetic reference model.
module tb_rv_muldiv_unit;

    localparam int XLEN = 32;
    localparam int NORM_LAT = XLEN + 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rv_muldiv_unit_if #(.XLEN(XLEN)) bus ();

    rv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return NORM_LAT;
    endfunction

    // Issue one request, wait for the result, then complete the handshake.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output logic [31:0] res);
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.result;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %0b want 0", bus.busy);
        end
        checks++;
        if (bus.result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result got %08h want 0", bus.result);
        end
    endtask

    logic [2:0]  d_op  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6,
                                3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'h7, 32'hFFFFFFFF, 32'h80000000,
                                32'hFFFFFFFF, 32'hFFFFFFEC, 32'hFFFFFFEC,
                                32'hFFFFFFFF, 32'd100, 32'd5, 32'd5,
                                32'h80000000, 32'h80000000};
    logic [31:0] d_b   [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                                32'hFFFFFFFF, 32'd6, 32'd6, 32'h10, 32'd7,
                                32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_exp [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000,
                                32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFE,
                                32'h0FFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd5,
                                32'h80000000, 32'd0};
    int          d_lat [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

    task automatic test_directed();
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 12; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], lat, res);
            checks++;
            if (res !== d_exp[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] op=%0d got %08h want %08h",
                         i, d_op[i], res, d_exp[i]);
            end
            checks++;
            if (lat != d_lat[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d want %0d",
                         i, lat, d_lat[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        int sel;
        logic [2:0] op;
        logic [31:0] a, b, res, exp;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) b = 32'($urandom_range(1, 15));
            exp = ref_model(op, a, b);
            run_op(op, a, b, lat, res);
            checks++;
            if (res !== exp) begin
                errors++;
                $display("FAIL random_result op=%0d a=%08h b=%08h got %08h want %08h",
                         op, a, b, res, exp);
            end
            checks++;
            if (lat != ref_latency(op, a, b)) begin
                errors++;
                $display("FAIL random_latency op=%0d got %0d want %0d",
                         op, lat, ref_latency(op, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] exp, res;
        exp = ref_model(3'd0, 32'h1234, 32'h10);
        bus.op       = 3'd0;
        bus.src_a    = 32'h1234;
        bus.src_b    = 32'h10;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== exp) begin
                errors++;
                $display("FAIL hold_output cyc %0d valid %0b res %08h want 1 %08h",
                         i, bus.out_valid, bus.result, exp);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_in_ready cyc %0d got %0b want 0",
                         i, bus.in_ready);
            end
        end
        bus.op        = 3'd5;
        bus.src_a     = 32'd1000;
        bus.src_b     = 32'd10;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL turnaround_idle rdy %0b valid %0b busy %0b want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL turnaround_accept busy got %0b want 1", bus.busy);
        end
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        res = bus.result;
        checks++;
        if (res !== 32'd100 || n != NORM_LAT) begin
            errors++;
            $display("FAIL turnaround_result got %08h lat %0d want 00000064 lat %0d",
                     res, n, NORM_LAT);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        int lat;
        logic seen;
        logic [31:0] res;
        bus.op       = 3'd0;
        bus.src_a    = 32'd1234;
        bus.src_b    = 32'd5678;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        bus.flush    = 1'b1;
        bus.op       = 3'd5;
        bus.src_a    = 32'd50;
        bus.src_b    = 32'd5;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle busy %0b rdy %0b valid %0b want 0 1 0",
                     bus.busy, bus.in_ready, bus.out_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_quiet activity got %0b want 0", seen);
        end
        run_op(3'd0, 32'd3, 32'd4, lat, res);
        checks++;
        if (res !== 32'd12 || lat != NORM_LAT) begin
            errors++;
            $display("FAIL flush_after_mul got %08h lat %0d want 0000000c lat %0d",
                     res, lat, NORM_LAT);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] res;
        bus.op       = 3'd5;
        bus.src_a    = 32'd77777;
        bus.src_b    = 32'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL async_reset rdy %0b valid %0b busy %0b res %08h want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.result);
        end
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(3'd5, 32'd9, 32'd3, lat, res);
        checks++;
        if (res !== 32'd3 || lat != NORM_LAT) begin
            errors++;
            $display("FAIL reset_then_divu got %08h lat %0d want 00000003 lat %0d",
                     res, lat, NORM_LAT);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
